// File: rtl/forward_hazard_unit.sv
// Operand bypass and hazard detection at the ID/EX boundary: byte-merged forwarding from
// EX/MEM, MEM/WB and a one-cycle writeback shadow, plus load-use/partial-write stall bookkeeping.
module forward_hazard_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int MAX_STALL  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] id_addr,
    input  logic [NUM_READ*DATA_WIDTH-1:0] id_rf_data,
    input  logic [ADDR_WIDTH-1:0]          exmem_rd_addr,
    input  logic [DATA_WIDTH/8-1:0]        exmem_byte_en,
    input  logic                           exmem_is_load,
    input  logic [DATA_WIDTH-1:0]          exmem_data,
    input  logic [ADDR_WIDTH-1:0]          memwb_rd_addr,
    input  logic [DATA_WIDTH/8-1:0]        memwb_byte_en,
    input  logic [DATA_WIDTH-1:0]          memwb_data,
    output logic [NUM_READ*DATA_WIDTH-1:0] fwd_data,
    output logic [NUM_READ*2-1:0]          fwd_sel,
    output logic                           stall,
    output logic                           stall_timeout,
    output logic [CNT_WIDTH-1:0]           stall_total
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int RL_W = $clog2(MAX_STALL + 1);
    localparam logic [RL_W-1:0] RUN_LEN_LAST = RL_W'(MAX_STALL - 1);

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    logic                  shadow_valid;
    logic [ADDR_WIDTH-1:0] shadow_addr;
    logic [BE_W-1:0]       shadow_be;
    logic [DATA_WIDTH-1:0] shadow_data;
    logic [NUM_READ-1:0]   hz_vec;

    state_t          state, state_next;
    logic [RL_W-1:0] run_len, run_len_next;
    logic            timeout_next;

    // Shadow holds last cycle's writeback so a same-cycle regfile write/read race still bypasses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            shadow_valid <= 1'b0;
            shadow_addr  <= '0;
            shadow_be    <= '0;
            shadow_data  <= '0;
        end else if (memwb_byte_en != '0 && memwb_rd_addr != '0) begin
            shadow_valid <= 1'b1;
            shadow_addr  <= memwb_rd_addr;
            shadow_be    <= memwb_byte_en;
            shadow_data  <= memwb_data;
        end else begin
            shadow_valid <= 1'b0;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] merged;
        logic                  mw_hit;
        logic                  sh_hit;
        logic                  ex_full;

        assign addr = id_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Shadow bytes first, then MEM/WB bytes, so the newer writer wins per byte.
        always_comb begin
            // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
            merged = id_rf_data[p*DATA_WIDTH +: DATA_WIDTH];
            mw_hit = 1'b0;
            sh_hit = 1'b0;
            if (addr != '0) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (shadow_valid && shadow_addr == addr && shadow_be[k]) begin
                        merged[k*8 +: 8] = shadow_data[k*8 +: 8];
                        sh_hit           = 1'b1;
                    end
                    if (memwb_rd_addr == addr && memwb_byte_en[k]) begin
                        merged[k*8 +: 8] = memwb_data[k*8 +: 8];
                        mw_hit           = 1'b1;
                    end
                end
            end
        end

        assign ex_full = (addr != '0) && (exmem_rd_addr == addr) && (&exmem_byte_en)
                         && !exmem_is_load;

        assign fwd_data[p*DATA_WIDTH +: DATA_WIDTH] = ex_full ? exmem_data : merged;
        assign fwd_sel[p*2 +: 2] = ex_full ? 2'b01 :
                                   mw_hit  ? 2'b10 :
                                   sh_hit  ? 2'b11 : 2'b00;

        assign hz_vec[p] = id_valid && (addr != '0) && (addr == exmem_rd_addr)
                           && (exmem_byte_en != '0)
                           && (exmem_is_load || !(&exmem_byte_en));
    end

    assign stall = |hz_vec;

    always_comb begin
        state_next   = state;
        run_len_next = '0;
        timeout_next = stall_timeout;
        unique case (state)
            RUN:   if (stall) state_next = STALL;
            STALL: if (!stall) state_next = RUN;
            default: state_next = RUN;
        endcase
        if (stall) begin
            run_len_next = (run_len == RUN_LEN_LAST) ? run_len : run_len + RL_W'(1);
            if (run_len == RUN_LEN_LAST) timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            run_len       <= '0;
            stall_timeout <= 1'b0;
            stall_total   <= '0;
        end else begin
            state         <= state_next;
            run_len       <= run_len_next;
            stall_timeout <= timeout_next;
            if (stall && !(&stall_total)) stall_total <= stall_total + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_forward_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid;
    logic [NR*AW-1:0] id_addr;
    logic [NR*DW-1:0] id_rf_data;
    logic [AW-1:0]  exmem_rd_addr;
    logic [3:0]     exmem_byte_en;
    logic           exmem_is_load;
    logic [DW-1:0]  exmem_data;
    logic [AW-1:0]  memwb_rd_addr;
    logic [3:0]     memwb_byte_en;
    logic [DW-1:0]  memwb_data;
    logic [NR*DW-1:0] fwd_data;
    logic [NR*2-1:0]  fwd_sel;
    logic           stall;
    logic           stall_timeout;
    logic [CW-1:0]  stall_total;

    forward_hazard_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .MAX_STALL(16), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_addr(id_addr),
        .id_rf_data(id_rf_data), .exmem_rd_addr(exmem_rd_addr), .exmem_byte_en(exmem_byte_en),
        .exmem_is_load(exmem_is_load), .exmem_data(exmem_data), .memwb_rd_addr(memwb_rd_addr),
        .memwb_byte_en(memwb_byte_en), .memwb_data(memwb_data), .fwd_data(fwd_data),
        .fwd_sel(fwd_sel), .stall(stall), .stall_timeout(stall_timeout), .stall_total(stall_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [63:0]    data;
        logic [3:0]     sel;
        logic           stl;
        logic           to;
        logic [CW-1:0]  tot;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    logic          exp_timeout = 1'b0;
    logic [CW-1:0] exp_total   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".data"},  fwd_data,             e.data);
                check({e.name, ".sel"},   64'(fwd_sel),         64'(e.sel));
                check({e.name, ".stall"}, 64'(stall),           64'(e.stl));
                check({e.name, ".tmo"},   64'(stall_timeout),   64'(e.to));
                check({e.name, ".total"}, 64'(stall_total),     64'(e.tot));
            end
        end
    end

    // Push one cycle's expectation, advance one edge, then update the counter bookkeeping.
    task automatic step(input string name, input logic [63:0] d, input logic [3:0] s,
                        input logic st);
        exp_t e;
        e.name = name; e.data = d; e.sel = s; e.stl = st;
        e.to = exp_timeout; e.tot = exp_total;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_total   = '0;
            exp_timeout = 1'b0;
        end else if (st && exp_total != '1) begin
            exp_total = exp_total + 1'b1;
        end
    endtask

    task automatic set_idle();
        id_valid      = 1'b1;
        exmem_rd_addr = '0; exmem_byte_en = '0; exmem_is_load = 1'b0; exmem_data = '0;
        memwb_rd_addr = '0; memwb_byte_en = '0; memwb_data = '0;
    endtask

    task automatic set_load4();
        exmem_rd_addr = 5'd4; exmem_byte_en = 4'hF; exmem_is_load = 1'b1;
        exmem_data = 32'h55555555;
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0;
        set_idle();
        id_addr    = {5'd5, 5'd3};
        id_rf_data = {32'hBBBB0005, 32'hAAAA0003};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        step("reset_rf", {32'hBBBB0005, 32'hAAAA0003}, 4'b0000, 1'b0);

        exmem_rd_addr = 5'd3; exmem_byte_en = 4'hF; exmem_data = 32'hDEADBEEF;
        step("exmem_full", {32'hBBBB0005, 32'hDEADBEEF}, 4'b0001, 1'b0);

        set_idle();
        id_addr    = {5'd7, 5'd7};
        id_rf_data = {32'h11223344, 32'h11223344};
        memwb_rd_addr = 5'd7; memwb_byte_en = 4'b0011; memwb_data = 32'h0000ABCD;
        step("memwb_merge", {32'h1122ABCD, 32'h1122ABCD}, 4'b1010, 1'b0);
        set_idle();
        step("shadow_merge", {32'h1122ABCD, 32'h1122ABCD}, 4'b1111, 1'b0);
        step("shadow_expire", {32'h11223344, 32'h11223344}, 4'b0000, 1'b0);

        exmem_rd_addr = 5'd7; exmem_byte_en = 4'hF; exmem_data = 32'hCAFEF00D;
        memwb_rd_addr = 5'd7; memwb_byte_en = 4'hF; memwb_data = 32'h12345678;
        step("exmem_priority", {32'hCAFEF00D, 32'hCAFEF00D}, 4'b0101, 1'b0);
        set_idle();
        step("shadow_full", {32'h12345678, 32'h12345678}, 4'b1111, 1'b0);

        id_addr    = {5'd4, 5'd3};
        id_rf_data = {32'h44444444, 32'hAAAA0003};
        set_load4();
        for (int i = 0; i < 3; i++)
            step($sformatf("load_use%0d", i), {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b1);
        set_idle();
        step("load_release", {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b0);

        exmem_rd_addr = 5'd4; exmem_byte_en = 4'b0001; exmem_data = 32'h000000EE;
        memwb_rd_addr = 5'd4; memwb_byte_en = 4'b1100; memwb_data = 32'h99880000;
        step("partial_write", {32'h99884444, 32'hAAAA0003}, 4'b1000, 1'b1);

        set_idle();
        id_valid = 1'b0;
        set_load4();
        step("id_invalid", {32'h99884444, 32'hAAAA0003}, 4'b1100, 1'b0);

        set_idle();
        id_addr = {5'd0, 5'd0};
        exmem_byte_en = 4'hF; exmem_is_load = 1'b1;
        memwb_byte_en = 4'hF; memwb_data = 32'h99999999;
        step("addr_zero", {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b0);

        set_idle();
        id_addr = {5'd4, 5'd3};
        set_load4();
        for (int i = 0; i < 16; i++)
            step($sformatf("long_stall%0d", i), {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b1);
        exp_timeout = 1'b1;
        set_idle();
        step("timeout_set", {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b0);
        step("timeout_sticky", {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b0);

        set_load4();
        for (int i = 0; i < 14; i++)
            step($sformatf("saturate%0d", i), {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b1);
        set_idle();
        step("saturated", {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b0);

        set_load4();
        memwb_rd_addr = 5'd7; memwb_byte_en = 4'hF; memwb_data = 32'h77777777;
        rst_n = 1'b0;
        step("reset_mid_stall", {32'h44444444, 32'hAAAA0003}, 4'b0000, 1'b1);
        rst_n = 1'b1;
        set_idle();
        id_addr    = {5'd7, 5'd7};
        id_rf_data = {32'h11223344, 32'h11223344};
        step("after_reset", {32'h11223344, 32'h11223344}, 4'b0000, 1'b0);

        exmem_rd_addr = 5'd7; exmem_byte_en = 4'hF; exmem_is_load = 1'b1;
        step("restall", {32'h11223344, 32'h11223344}, 4'b0000, 1'b1);
        set_idle();
        step("recount", {32'h11223344, 32'h11223344}, 4'b0000, 1'b0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
